// File: rtl/aurora_pkg.sv
// Shared types and defaults for the Aurora-style TX scheduler: per-cycle
// ordered-set flags, scheduler state encoding and counter sizing helper.
package aurora_pkg;

    localparam int CC_PERIOD_DEFAULT = 10000;
    localparam int CC_LEN_DEFAULT    = 6;

    typedef struct packed {
        logic idle;
        logic scp;
        logic ecp;
        logic cc;
    } ordered_sets_t;

    typedef enum logic [2:0] {
        ST_DOWN,
        ST_IDLE,
        ST_SCP,
        ST_DATA,
        ST_ECP,
        ST_CC
    } sched_state_t;

    // Counter width that still works when the terminal count is 0.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tx_scheduler_if.sv
// TX user-beat handshake plus the ordered-set control symbols emitted per cycle.
// A beat transfers on a cycle where axi_valid && axi_ready; data_valid mirrors that.
interface tx_scheduler_if;
    import aurora_pkg::*;

    logic          axi_valid;
    logic          axi_last;
    logic          axi_ready;
    logic          data_valid;
    ordered_sets_t ordered_sets;

    modport master (
        output axi_valid, axi_last,
        input  axi_ready, data_valid, ordered_sets
    );

    modport slave (
        input  axi_valid, axi_last,
        output axi_ready, data_valid, ordered_sets
    );

endinterface

// File: rtl/cc_timer.sv
// Free-running clock-compensation period counter with a sticky request flag
// that the scheduler consumes when it starts a CC burst.
module cc_timer import aurora_pkg::*; #(
    parameter int CC_PERIOD = CC_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    input  logic take,
    output logic cc_pending
);

    localparam int            CW       = cnt_width(CC_PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(CC_PERIOD - 1);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = count_en && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt        <= '0;
            cc_pending <= 1'b0;
        end else begin
            if (count_en) begin
                cnt <= wrap ? '0 : cnt + 1'b1;
            end
            // A fresh request landing on the consume edge must not be lost.
            if (wrap) begin
                cc_pending <= 1'b1;
            end else if (take) begin
                cc_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tx_scheduler.sv
// TX scheduler: frames user beats with SCP/ECP, fills gaps with idles and
// preempts the stream with periodic CC bursts without losing beats.
module tx_scheduler import aurora_pkg::*; #(
    parameter int CC_PERIOD = CC_PERIOD_DEFAULT,
    parameter int CC_LEN    = CC_LEN_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           channel_init_finished,
    tx_scheduler_if.slave  tx,
    output sched_state_t   state
);

    localparam int            BW         = cnt_width(CC_LEN);
    localparam logic [BW-1:0] BURST_LAST = BW'(CC_LEN - 1);

    sched_state_t  resume;
    logic [BW-1:0] burst_cnt;
    logic          cc_pending;
    logic          accept;
    logic          last_beat;
    logic          cc_enter;
    ordered_sets_t os;

    assign accept    = tx.axi_valid && tx.axi_ready;
    assign last_beat = accept && tx.axi_last;

    // Closing a frame outranks a pending CC; the CC then follows from idle.
    assign cc_enter = channel_init_finished && cc_pending &&
                      ((state == ST_IDLE) || ((state == ST_DATA) && !last_beat));

    cc_timer #(.CC_PERIOD(CC_PERIOD)) u_cc_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (!channel_init_finished),
        .count_en   (state != ST_DOWN),
        .take       (cc_enter),
        .cc_pending (cc_pending)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || !channel_init_finished) begin
            state     <= ST_DOWN;
            resume    <= ST_IDLE;
            burst_cnt <= '0;
        end else begin
            case (state)
                ST_DOWN: state <= ST_IDLE;
                ST_IDLE: begin
                    if (cc_enter) begin
                        state     <= ST_CC;
                        resume    <= ST_IDLE;
                        burst_cnt <= '0;
                    end else if (tx.axi_valid) begin
                        state <= ST_SCP;
                    end
                end
                ST_SCP: state <= ST_DATA;
                ST_DATA: begin
                    if (last_beat) begin
                        state <= ST_ECP;
                    end else if (cc_enter) begin
                        state     <= ST_CC;
                        resume    <= ST_DATA;
                        burst_cnt <= '0;
                    end
                end
                ST_ECP: state <= ST_IDLE;
                ST_CC: begin
                    if (burst_cnt == BURST_LAST) begin
                        state <= resume;
                    end else begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: state <= ST_DOWN;
            endcase
        end
    end

    always_comb begin
        os      = '0;
        os.idle = (state == ST_IDLE) || ((state == ST_DATA) && !tx.axi_valid);
        os.scp  = (state == ST_SCP);
        os.ecp  = (state == ST_ECP);
        os.cc   = (state == ST_CC);
    end

    assign tx.ordered_sets = os;
    assign tx.axi_ready    = (state == ST_DATA);
    assign tx.data_valid   = accept;

endmodule

// File: tb/tb_tx_scheduler.sv
// Bench for tx_scheduler: directed scenario sequence with randomized frames,
// checked cycle by cycle against a phase/age reference model.
module tb_tx_scheduler;
    import aurora_pkg::*;

    localparam int P = 20;
    localparam int L = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cif = 1'b0;
    sched_state_t dbg_state;

    tx_scheduler_if tx_bus ();

    tx_scheduler #(.CC_PERIOD(P), .CC_LEN(L)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .channel_init_finished (cif),
        .tx                    (tx_bus),
        .state                 (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // Reference model: link phase plus "cycles up" age; a CC is due every P up-cycles.
    typedef enum {PH_DOWN, PH_GAP, PH_SOF, PH_PAYLOAD, PH_EOF, PH_CC} phase_e;
    phase_e ph = PH_DOWN;
    phase_e ph_after = PH_GAP;
    int age = 0;
    int cc_left = 0;
    bit pend = 1'b0;

    int beat_id = 0;
    logic last_dv = 1'b0;
    logic [3:0] last_os = 4'b0;
    int cc_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic c, input logic v, input logic l);
        bit wrap;
        bit enter;
        wrap = 1'b0;
        enter = 1'b0;
        if (!r || !c) begin
            ph = PH_DOWN;
            age = 0;
            pend = 1'b0;
        end else begin
            if (ph != PH_DOWN) begin
                age++;
                wrap = (age % P == 0);
            end
            case (ph)
                PH_DOWN: ph = PH_GAP;
                PH_GAP: begin
                    if (pend) begin enter = 1'b1; ph_after = PH_GAP; end
                    else if (v) ph = PH_SOF;
                end
                PH_SOF: ph = PH_PAYLOAD;
                PH_PAYLOAD: begin
                    if (v && l) ph = PH_EOF;
                    else if (pend) begin enter = 1'b1; ph_after = PH_PAYLOAD; end
                end
                PH_EOF: ph = PH_GAP;
                PH_CC: begin
                    cc_left--;
                    if (cc_left == 0) ph = ph_after;
                end
                default: ph = PH_DOWN;
            endcase
            if (enter) begin
                ph = PH_CC;
                cc_left = L;
                pend = 1'b0;
            end
            if (wrap) pend = 1'b1;
        end
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance model.
    task automatic cycle(input logic r, input logic c, input logic v, input logic l);
        logic       exp_ready;
        logic       exp_dv;
        logic [3:0] exp_os;
        rst_n = r;
        cif = c;
        tx_bus.axi_valid = v;
        tx_bus.axi_last = l;
        @(negedge clk);
        exp_ready = (ph == PH_PAYLOAD);
        exp_dv = exp_ready && v;
        exp_os = {(ph == PH_GAP) || ((ph == PH_PAYLOAD) && !v), ph == PH_SOF,
                  ph == PH_EOF, ph == PH_CC};
        chk("axi_ready", 32'(tx_bus.axi_ready), 32'(exp_ready));
        chk("data_valid", 32'(tx_bus.data_valid), 32'(exp_dv));
        chk("ordered_sets", 32'(tx_bus.ordered_sets), 32'(exp_os));
        chk("os_at_most_one", 32'($countones(tx_bus.ordered_sets) <= 1), 32'd1);
        last_dv = tx_bus.data_valid;
        last_os = tx_bus.ordered_sets;
        if (tx_bus.ordered_sets.cc) cc_seen++;
        if (tx_bus.data_valid) begin
            if (exp_q.size() == 0) chk("beat_extra", 32'd1, 32'd0);
            else chk("beat_order", 32'(beat_id), exp_q.pop_front());
        end
        model_step(r, c, v, l);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int n, input int gap_pct, input int budget);
        int sent;
        int cyc;
        logic v;
        sent = 0;
        cyc = 0;
        for (int i = 0; i < n; i++) exp_q.push_back(32'(i));
        while (sent < n && cyc < budget) begin
            v = ($urandom_range(99) >= gap_pct);
            beat_id = sent;
            cycle(1'b1, 1'b1, v, v && (sent == n - 1));
            if (last_dv) sent++;
            cyc++;
        end
        chk("frame_beats_sent", 32'(sent), 32'(n));
        chk("frame_queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cc_base;
        int guard;
        logic [3:0] seq_exp [5];
        tx_bus.axi_valid = 1'b0;
        tx_bus.axi_last = 1'b0;
        @(posedge clk);
        #1;

        // Reset with random side inputs
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
        chk("reset_state", 32'(dbg_state), 32'(ST_DOWN));
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);

        // Bring-up, idle fill, first CC burst after one period
        cc_base = cc_seen;
        idle(26);
        chk("first_cc_burst_len", 32'(cc_seen - cc_base), 32'(L));

        // Short frame with valid held, then a long continuous frame
        send_frame(3, 0, 40);
        idle(2);
        cc_base = cc_seen;
        send_frame(100, 0, 400);
        chk("long_frame_cc_bursts", 32'(cc_seen - cc_base >= 3 * L), 32'd1);
        idle(3);

        // Last beat accepted in the very cycle a CC request is pending
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        beat_id = 0;
        guard = 0;
        last_dv = 1'b0;
        while (!last_dv && guard < 60) begin cycle(1'b1, 1'b1, 1'b1, 1'b0); guard++; end
        chk("race_first_beat", 32'(last_dv), 32'd1);
        beat_id = 1;
        guard = 0;
        while (!(pend && ph == PH_PAYLOAD) && guard < 60) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        chk("race_pending_seen", 32'(pend && ph == PH_PAYLOAD), 32'd1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        chk("race_last_accepted", 32'(last_dv), 32'd1);
        seq_exp = '{4'b0010, 4'b1000, 4'b0001, 4'b0001, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("race_ecp_idle_cc_seq", 32'(last_os), 32'(seq_exp[i]));
        end
        exp_q.delete();
        idle(2);

        // Random frames with random in-frame gaps
        for (int f = 0; f < 8; f++) begin
            send_frame($urandom_range(8, 1), 30, 80);
            idle($urandom_range(3, 0));
        end

        // Channel drop while the second beat is offered
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i));
        beat_id = 0;
        guard = 0;
        last_dv = 1'b0;
        while (!last_dv && guard < 60) begin cycle(1'b1, 1'b1, 1'b1, 1'b0); guard++; end
        chk("drop_first_beat", 32'(last_dv), 32'd1);
        beat_id = 1;
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("drop_state_down", 32'(dbg_state), 32'(ST_DOWN));
        chk("drop_outputs_zero", 32'({tx_bus.axi_ready, tx_bus.ordered_sets}), 32'd0);
        exp_q.delete();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'($urandom_range(1)), 1'b0);
        send_frame(4, 0, 40);
        idle(2);

        // Reset during the second cycle of a CC burst
        guard = 0;
        while (!(ph == PH_CC && cc_left == L - 1) && guard < 60) begin idle(1); guard++; end
        chk("cc_burst_reached", 32'(ph == PH_CC && cc_left == L - 1), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("cc_reset_state", 32'(dbg_state), 32'(ST_DOWN));
        chk("cc_reset_outputs", 32'({tx_bus.axi_ready, tx_bus.data_valid, tx_bus.ordered_sets}), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cc_base = cc_seen;
        idle(26);
        chk("cc_after_reset_len", 32'(cc_seen - cc_base), 32'(L));
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
